pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing the fixed 2x32-bit IF/ID latch.
- Carries a DATA_W payload, e.g. {pc4, inst}, under a valid/ready handshake.
- Supports stall via backpressure, synchronous flush for branch/jump squash, and bubble insertion.
- An optional skid slot makes in_ready a pure register output, breaking the combinational ready path through the pipeline.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int IF_ID_W = 64;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Occupancy of a pipeline stage: nothing held, main entry held,
  // main and skid entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready payload hand-off with flush and bubble fill.
// Latency: 1 cycle from in_fire to out_valid/out_data (both registered).
// Backpressure: base build stalls via combinational in_ready = ~out_valid | out_ready;
//   with PIPE_STAGE_REG_SKID_EN a skid entry absorbs one beat and in_ready is registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;

`ifdef PIPE_STAGE_REG_SKID_EN
  // Second entry holding the beat accepted while downstream was stalled.
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;

  assign in_ready = in_ready_q;
`else
  // Single entry: we can take a new beat if empty or if the current one leaves now.
  assign in_ready = ~out_valid_q | out_ready;
`endif

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // Next-state and next-payload selection; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
`ifdef PIPE_STAGE_REG_SKID_EN
        if (in_fire && !out_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (in_fire && out_fire) begin
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
        end
`else
        // in_fire implies out_ready here, so the entry is simply replaced.
        if (in_fire) begin
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
        end
`endif
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      FULL: begin
        // in_ready is low in FULL, so only the drain edge can move us.
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
        end
      end
`endif
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE_VAL;
      end
    endcase

    // A coincident in_fire is swallowed; a coincident out_fire already left.
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_d  = BUBBLE_VAL;
`endif
    end
  end

  // State and payload registers; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE_VAL;
      out_valid_q <= 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q      <= BUBBLE_VAL;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= (state_d != EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (bubble 0 and bubble 0x13)
// share stimulus; an occupancy queue model predicts ready/valid/data.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [63:0] BUB_A = 64'h0;
  localparam logic [63:0] BUB_B = 64'h13;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = 64'h0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [63:0] out_data_a, out_data_b;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic        last_fire;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB_A)) dut_a (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
  );

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB_B)) dut_b (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check in_ready against the model,
  // then fold accept/flush/reset into the model after the edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic ord,
                       input logic fl, input logic rn);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    flush     = fl;
    clrn      = rn;
    #1;
    if (SKID) exp_rdy = (exp_q.size() < 2);
    else      exp_rdy = (exp_q.size() == 0) || ord;
    check("in_ready_a", {63'h0, in_ready_a}, {63'h0, exp_rdy});
    check("in_ready_b", {63'h0, in_ready_b}, {63'h0, exp_rdy});
    last_fire = v && exp_rdy;
    @(posedge clk);
    #1;
    if (!rn || fl) exp_q.delete();
    else if (last_fire) exp_q.push_back(d);
  endtask

  // Monitor: compares presented outputs with the queue head and retires beats
  // that downstream accepts.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("out_valid_a", {63'h0, out_valid_a}, {63'h0, exp_q.size() != 0});
      check("out_valid_b", {63'h0, out_valid_b}, {63'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("out_data_a", out_data_a, exp_q[0]);
        check("out_data_b", out_data_b, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("bubble_a", out_data_a, BUB_A);
        check("bubble_b", out_data_b, BUB_B);
      end
    end
  end

  initial begin
    logic pending;
    // Reset held with a valid beat offered; nothing must get through.
    cycle(1'b1, 64'hDEAD_BEEF_0000_0004, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'hDEAD_BEEF_0000_0004, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Streaming four beats back to back.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 64'(i * 16), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Stall: 0x10 held while 0x20 is offered, then drain in order.
    cycle(1'b1, 64'h10, 1'b0, 1'b0, 1'b1);
    pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(pending, 64'h20, 1'b0, 1'b0, 1'b1);
      if (last_fire) pending = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(pending, 64'h20, 1'b1, 1'b0, 1'b1);
      if (last_fire) pending = 1'b0;
    end

    // Flush with both entries occupied (skid build) or one entry (base).
    cycle(1'b1, 64'h10, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h20, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Flush coinciding with accept of 0x30 and delivery of 0x10.
    cycle(1'b1, 64'h10, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h30, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with an entry held.
    cycle(1'b1, 64'h55, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 63) != 0));
    end

    // Drain and confirm both bubbles once idle.
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
